// File: rtl/sysbus_if.sv
// Sysbus request/response handshake bundle between an initiator (master) and a memory responder (slave).
interface sysbus_if #(
    parameter int unsigned TAG_W = 13
);
    logic             reqcyc;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqack;
    logic             respcyc;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Line-granular Sysbus memory responder: 8-beat reads, 8-beat writes plus one completion beat.
// Optional macro SYSBUS_MEM_CRITICAL_WORD_FIRST_EN starts read bursts at the requested word.
module sysbus_mem_responder #(
    parameter int unsigned MEM_WORDS = 8192,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned TAG_W     = 13
) (
    input  logic     clk,
    input  logic     reset,
    sysbus_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned LINE_W = IDX_W - 3;
    localparam int unsigned CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [3:0]  TYPE_MEMORY = 4'h1;

    typedef enum logic [2:0] {IDLE, WAIT, RDATA, WDATA, WRESP} state_t;

    state_t            state;
    logic [LINE_W-1:0] line_q;
    logic [2:0]        beat_q;
    logic [2:0]        start_q;
    logic [CNT_W-1:0]  lat_q;
    logic [TAG_W-1:0]  tag_q;
    logic              is_mem_q;

    // Simulation memory model: zero at time zero, never touched by reset.
    logic [63:0] mem [MEM_WORDS] = '{default: '0};

    logic [2:0]       rd_beat_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic [63:0]      rd_word_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic             wr_en_c;

    // Word for the beat that will be presented next; unknown types read as zero.
    always_comb begin
        rd_beat_c = (state == RDATA) ? beat_q + 3'd1 : 3'd0;
        rd_idx_c  = {line_q, 3'(start_q + rd_beat_c)};
        rd_word_c = is_mem_q ? mem[rd_idx_c] : 64'd0;
        wr_idx_c  = {line_q, beat_q};
        wr_en_c   = !reset && (state == WDATA) && bus.reqcyc && is_mem_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_idx_c] <= bus.req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bus.reqack  <= 1'b0;
            bus.respcyc <= 1'b0;
            bus.resp    <= 64'd0;
            bus.resptag <= '0;
            line_q      <= '0;
            beat_q      <= 3'd0;
            start_q     <= 3'd0;
            lat_q       <= '0;
            tag_q       <= '0;
            is_mem_q    <= 1'b0;
        end else begin
            bus.reqack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.reqcyc) begin
                        line_q     <= bus.req[6 +: LINE_W];
                        tag_q      <= bus.reqtag;
                        is_mem_q   <= (bus.reqtag[TAG_W-2 -: 4] == TYPE_MEMORY);
                        beat_q     <= 3'd0;
                        lat_q      <= '0;
                        bus.reqack <= 1'b1;
`ifdef SYSBUS_MEM_CRITICAL_WORD_FIRST_EN
                        start_q    <= bus.reqtag[TAG_W-1] ? bus.req[5:3] : 3'd0;
`else
                        start_q    <= 3'd0;
`endif
                        state      <= bus.reqtag[TAG_W-1] ? WAIT : WDATA;
                    end
                end
                WAIT: begin
                    if (lat_q == CNT_W'(LATENCY)) begin
                        state       <= RDATA;
                        bus.respcyc <= 1'b1;
                        bus.resp    <= rd_word_c;
                        bus.resptag <= tag_q;
                    end else begin
                        lat_q <= lat_q + CNT_W'(1);
                    end
                end
                RDATA: begin
                    if (bus.respack) begin
                        if (beat_q == 3'd7) begin
                            state       <= IDLE;
                            bus.respcyc <= 1'b0;
                            bus.resp    <= 64'd0;
                            beat_q      <= 3'd0;
                        end else begin
                            beat_q   <= beat_q + 3'd1;
                            bus.resp <= rd_word_c;
                        end
                    end
                end
                WDATA: begin
                    if (bus.reqcyc) begin
                        bus.reqack <= 1'b1;
                        beat_q     <= beat_q + 3'd1;
                        if (beat_q == 3'd7) begin
                            state       <= WRESP;
                            bus.respcyc <= 1'b1;
                            bus.resp    <= 64'd0;
                            bus.resptag <= tag_q;
                            beat_q      <= 3'd0;
                        end
                    end
                end
                WRESP: begin
                    if (bus.respack) begin
                        state       <= IDLE;
                        bus.respcyc <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Protocol checks on the initiator side of the handshake.
    a_respack_needs_respcyc: assert property (@(posedge clk) disable iff (reset)
        bus.respack |-> bus.respcyc)
        else $fatal(1, "respack asserted while respcyc is low");

    a_reqcyc_while_busy: assert property (@(posedge clk) disable iff (reset)
        (bus.reqcyc && (state inside {WAIT, RDATA, WRESP})) |-> (bus.reqack || $past(bus.reqack)))
        else $error("reqcyc held while responder is busy");

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder with a transaction-level memory model and per-beat scoreboard.
module tb_sysbus_mem_responder;
    localparam int unsigned MW  = 8192;
    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic reset;
    logic ack_en;

    sysbus_if #(.TAG_W(13)) bus ();

    sysbus_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .TAG_W(13)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Initiator consumes beats whenever it is willing; never acks an absent beat.
    assign bus.respack = bus.respcyc & ack_en;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] model_mem [MW];
    logic [63:0] exp_data [$];
    logic [12:0] exp_tag  [$];
    logic [63:0] got_q    [$];

    int ack_cnt  = 0;
    int cyc      = 0;
    int ack_cyc  = 0;
    int rise_cyc = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every consumed beat against the model, and held beats must not change.
    logic        prev_respcyc = 1'b0;
    logic        prev_stall   = 1'b0;
    logic [63:0] prev_resp    = '0;
    logic [12:0] prev_tag     = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (bus.reqack) begin
                ack_cnt++;
                ack_cyc = cyc;
            end
            if (bus.respcyc && !prev_respcyc) rise_cyc = cyc;
            if (bus.respcyc && prev_stall) begin
                check64("hold_resp", bus.resp, prev_resp);
                check64("hold_tag", 64'(bus.resptag), 64'(prev_tag));
            end
            if (bus.respcyc && bus.respack) begin
                check64("beat_pending", 64'(exp_data.size() > 0), 64'd1);
                if (exp_data.size() > 0) begin
                    check64("beat_data", bus.resp, exp_data.pop_front());
                    check64("beat_tag", 64'(bus.resptag), 64'(exp_tag.pop_front()));
                end
                got_q.push_back(bus.resp);
            end
        end
        prev_respcyc = !reset && bus.respcyc;
        prev_stall   = !reset && bus.respcyc && !bus.respack;
        prev_resp    = bus.resp;
        prev_tag     = bus.resptag;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned line_word(input logic [63:0] addr);
        return ((32'(addr >> 3)) % MW) & ~32'd7;
    endfunction

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                            input logic [63:0] first, input logic [63:0] step);
        int unsigned w0 = line_word(addr);
        logic [63:0] d = first;
        for (int i = 0; i < 8; i++) begin
            if (tag[11:8] == 4'h1) model_mem[w0 + i] = first + 64'(i) * step;
        end
        exp_data.push_back(64'd0);
        exp_tag.push_back(tag);
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = tag;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.req = d;
            d = d + step;
            tick();
        end
        bus.reqcyc = 1'b0;
        bus.req    = '0;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input int hold);
        int unsigned w0 = line_word(addr);
        int unsigned off = 0;
`ifdef SYSBUS_MEM_CRITICAL_WORD_FIRST_EN
        off = 32'(addr[5:3]);
`endif
        for (int i = 0; i < 8; i++) begin
            exp_data.push_back(tag[11:8] == 4'h1 ? model_mem[w0 + ((off + i) & 7)] : 64'd0);
            exp_tag.push_back(tag);
        end
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = tag;
        repeat (1 + hold) tick();
        bus.reqcyc = 1'b0;
        bus.req    = '0;
    endtask

    task automatic wait_done(input string name);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (exp_data.size() == 0 && !bus.respcyc) done = 1'b1;
        end
        check64(name, 64'(done), 64'd1);
        tick();
    endtask

    initial begin
        int a0;
        int b0;
        int held;
        bit found;

        for (int i = 0; i < MW; i++) model_mem[i] = '0;
        reset      = 1'b1;
        ack_en     = 1'b1;
        bus.reqcyc = 1'b0;
        bus.req    = '0;
        bus.reqtag = '0;
        repeat (3) tick();
        check64("rst_reqack", 64'(bus.reqack), 64'd0);
        check64("rst_respcyc", 64'(bus.respcyc), 64'd0);
        check64("rst_resp", bus.resp, 64'd0);
        check64("rst_resptag", 64'(bus.resptag), 64'd0);
        reset = 1'b0;
        tick();

        // Write line 0x1000 with 0x11..0x88.
        a0 = ack_cnt; b0 = got_q.size();
        do_write(64'h1000, 13'h0121, 64'h11, 64'h11);
        wait_done("wr1_timeout");
        check64("wr1_acks", 64'(ack_cnt - a0), 64'd9);
        check64("wr1_completion", got_q[b0], 64'd0);

        // Read back with respack following respcyc.
        a0 = ack_cnt; b0 = got_q.size();
        do_read(64'h1000, 13'h1122, 0);
        wait_done("rd1_timeout");
        check64("rd1_acks", 64'(ack_cnt - a0), 64'd1);
        check64("rd1_first", got_q[b0], 64'h11);
        check64("rd1_last", got_q[b0 + 7], 64'h88);
        check64("rd1_latency", 64'(rise_cyc - ack_cyc), 64'(LAT + 1));

        // Stall three cycles on beat 2.
        b0 = got_q.size();
        do_read(64'h1000, 13'h1123, 0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus.respcyc && bus.resp == 64'h33) found = 1'b1;
            else tick();
        end
        check64("stall_found", 64'(found), 64'd1);
        ack_en = 1'b0;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.respcyc && bus.resp == 64'h33) held++;
            if (i < 3) tick();
        end
        ack_en = 1'b1;
        wait_done("stall_timeout");
        check64("stall_held", 64'(held), 64'd4);
        check64("stall_last", got_q[b0 + 7], 64'h88);

        // Core-style: reqcyc held through the ack cycle and one more.
        a0 = ack_cnt; b0 = got_q.size();
        do_read(64'h1000, 13'h1124, 2);
        wait_done("core_timeout");
        repeat (10) tick();
        check64("core_acks", 64'(ack_cnt - a0), 64'd1);
        check64("core_beats", 64'(got_q.size() - b0), 64'd8);

        // Aliased write lands on line 0x1000.
        do_write(64'(MW) * 64'd8 + 64'h1000, 13'h0125, 64'hA1, 64'h1);
        wait_done("alias_wr_timeout");
        b0 = got_q.size();
        do_read(64'h1000, 13'h1126, 0);
        wait_done("alias_rd_timeout");
        check64("alias_first", got_q[b0], 64'hA1);
        check64("alias_last", got_q[b0 + 7], 64'hA8);

        // Restore pattern, then reset during beat 4 of a read.
        do_write(64'h1000, 13'h0127, 64'h11, 64'h11);
        wait_done("restore_timeout");
        do_read(64'h1000, 13'h1128, 0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus.respcyc && bus.resp == 64'h55) found = 1'b1;
            else tick();
        end
        check64("rst_mid_found", 64'(found), 64'd1);
        reset = 1'b1;
        tick();
        check64("rst_mid_respcyc", 64'(bus.respcyc), 64'd0);
        check64("rst_mid_reqack", 64'(bus.reqack), 64'd0);
        exp_data.delete();
        exp_tag.delete();
        reset = 1'b0;
        tick();
        b0 = got_q.size();
        do_read(64'h1000, 13'h1129, 0);
        wait_done("post_rst_timeout");
        check64("post_rst_beats", 64'(got_q.size() - b0), 64'd8);
        check64("post_rst_first", got_q[b0], 64'h11);

        // Read starting mid-line.
        b0 = got_q.size();
        do_read(64'h1028, 13'h112A, 0);
        wait_done("cwf_timeout");
`ifdef SYSBUS_MEM_CRITICAL_WORD_FIRST_EN
        check64("cwf_first", got_q[b0], 64'h66);
        check64("cwf_fourth", got_q[b0 + 3], 64'h11);
`else
        check64("cwf_first", got_q[b0], 64'h11);
        check64("cwf_fourth", got_q[b0 + 3], 64'h44);
`endif

        // Unknown type: completion only, zero read data, memory untouched.
        b0 = got_q.size();
        do_write(64'h1000, 13'h0230, 64'hDEAD_0000, 64'h1);
        wait_done("unk_wr_timeout");
        check64("unk_wr_completion", got_q[b0], 64'd0);
        b0 = got_q.size();
        do_read(64'h1000, 13'h1231, 0);
        wait_done("unk_rd_timeout");
        check64("unk_rd_beat3", got_q[b0 + 3], 64'd0);
        b0 = got_q.size();
        do_read(64'h1000, 13'h1132, 0);
        wait_done("unk_keep_timeout");
        check64("unk_keep_first", got_q[b0], 64'h11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
